// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared state encodings, response codes and arbitration modes
package bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR_ISSUE = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_WR_RESP  = 3'd3;
  localparam state_t ST_RD_RESP  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ARB_WRITE_PRIO  = 0;
  localparam int ARB_READ_PRIO   = 1;
  localparam int ARB_ROUND_ROBIN = 2;

endpackage

// File: rtl/axil_skid_reg.sv
// rtl/axil_skid_reg.sv - one-entry valid/ready holding register
// Ready only while empty; the entry stays put until the consumer pulses clear.
module axil_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             clear
);

  logic full;

  assign in_ready  = !full;
  assign out_valid = full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full     <= 1'b1;
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/axil_mem_bridge.sv
// rtl/axil_mem_bridge.sv - AXI4-Lite slave to single-outstanding memory strobe bridge
// Holding registers stay full until the response handshake, so requests arriving mid-transaction wait.
module axil_mem_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  core_read_memory,
  output logic                  core_write_memory,
  output logic [ADDR_WIDTH-1:0] core_address_memory,
  output logic [DATA_WIDTH-1:0] core_write_data_memory,
  output logic [STRB_WIDTH-1:0] core_write_strb_memory,
  input  logic [DATA_WIDTH-1:0] core_read_data_memory,
  input  logic                  core_memory_response
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                         state;
  logic                           aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]          aw_addr, ar_addr;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_bus;
  logic                           wr_done, rd_done;
  logic                           wr_pend, rd_pend, grant_wr, grant_rd;
  logic                           last_wr, timed_out;
  logic [CNT_W-1:0]               cnt;

  assign wr_done = (state == ST_WR_RESP) && bvalid && bready;
  assign rd_done = (state == ST_RD_RESP) && rvalid && rready;

  axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_aw (
    .clk(clk), .reset(reset), .in_valid(awvalid), .in_ready(awready), .in_data(awaddr),
    .out_valid(aw_full), .out_data(aw_addr), .clear(wr_done)
  );

  axil_skid_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w (
    .clk(clk), .reset(reset), .in_valid(wvalid), .in_ready(wready), .in_data({wstrb, wdata}),
    .out_valid(w_full), .out_data(w_bus), .clear(wr_done)
  );

  axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_ar (
    .clk(clk), .reset(reset), .in_valid(arvalid), .in_ready(arready), .in_data(araddr),
    .out_valid(ar_full), .out_data(ar_addr), .clear(rd_done)
  );

  assign wr_pend   = aw_full && w_full;
  assign rd_pend   = ar_full;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Round-robin history only moves on a contested grant.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_pend && rd_pend) begin
      if (ARB_MODE == ARB_READ_PRIO)             grant_rd = 1'b1;
      else if (ARB_MODE == ARB_ROUND_ROBIN)
        if (last_wr)                             grant_rd = 1'b1;
        else                                     grant_wr = 1'b1;
      else                                       grant_wr = 1'b1;
    end else begin
      grant_wr = wr_pend;
      grant_rd = rd_pend;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      last_wr                <= 1'b1;
      cnt                    <= '0;
      bvalid                 <= 1'b0;
      bresp                  <= RESP_OKAY;
      rvalid                 <= 1'b0;
      rresp                  <= RESP_OKAY;
      rdata                  <= '0;
      core_read_memory       <= 1'b0;
      core_write_memory      <= 1'b0;
      core_address_memory    <= '0;
      core_write_data_memory <= '0;
      core_write_strb_memory <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant_wr) begin
            if (rd_pend) last_wr <= 1'b1;
            if ((aw_addr & ALIGN_MASK) != '0) begin
              state  <= ST_WR_RESP;
              bvalid <= 1'b1;
              bresp  <= RESP_SLVERR;
            end else begin
              state                  <= ST_WR_ISSUE;
              core_write_memory      <= 1'b1;
              core_address_memory    <= aw_addr;
              core_write_data_memory <= w_bus[DATA_WIDTH-1:0];
              core_write_strb_memory <= w_bus[DATA_WIDTH+STRB_WIDTH-1:DATA_WIDTH];
            end
          end else if (grant_rd) begin
            if (wr_pend) last_wr <= 1'b0;
            if ((ar_addr & ALIGN_MASK) != '0) begin
              state  <= ST_RD_RESP;
              rvalid <= 1'b1;
              rresp  <= RESP_SLVERR;
              rdata  <= '0;
            end else begin
              state               <= ST_RD_ISSUE;
              core_read_memory    <= 1'b1;
              core_address_memory <= ar_addr;
            end
          end
        end
        ST_WR_ISSUE, ST_RD_ISSUE: begin
          if (core_memory_response || timed_out) begin
            core_write_memory <= 1'b0;
            core_read_memory  <= 1'b0;
            if (state == ST_RD_ISSUE) begin
              state  <= ST_RD_RESP;
              rvalid <= 1'b1;
              rresp  <= core_memory_response ? RESP_OKAY : RESP_SLVERR;
              rdata  <= core_memory_response ? core_read_data_memory : '0;
            end else begin
              state  <= ST_WR_RESP;
              bvalid <= 1'b1;
              bresp  <= core_memory_response ? RESP_OKAY : RESP_SLVERR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_bridge.sv
// tb/tb_axil_mem_bridge.sv - directed and randomized bench for axil_mem_bridge
module tb_axil_mem_bridge;
  import bridge_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        core_read_memory, core_write_memory;
  logic [31:0] core_address_memory, core_write_data_memory;
  logic [3:0]  core_write_strb_memory;
  logic [31:0] core_read_data_memory = 32'h0;
  logic        core_memory_response = 1'b0;

  axil_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .core_read_memory(core_read_memory), .core_write_memory(core_write_memory),
    .core_address_memory(core_address_memory), .core_write_data_memory(core_write_data_memory),
    .core_write_strb_memory(core_write_strb_memory), .core_read_data_memory(core_read_data_memory),
    .core_memory_response(core_memory_response)
  );

  // Second instance with a short timeout and a memory that never answers.
  logic        t_awvalid, t_awready, t_wvalid, t_wready, t_bvalid, t_bready;
  logic        t_arvalid, t_arready, t_rvalid, t_rready;
  logic [31:0] t_awaddr, t_wdata, t_araddr, t_rdata, t_addr, t_wdat;
  logic [3:0]  t_wstrb, t_strb;
  logic [1:0]  t_bresp, t_rresp;
  logic        t_rd_mem, t_wr_mem;

  axil_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset),
    .awvalid(t_awvalid), .awready(t_awready), .awaddr(t_awaddr),
    .wvalid(t_wvalid), .wready(t_wready), .wdata(t_wdata), .wstrb(t_wstrb),
    .bvalid(t_bvalid), .bready(t_bready), .bresp(t_bresp),
    .arvalid(t_arvalid), .arready(t_arready), .araddr(t_araddr),
    .rvalid(t_rvalid), .rready(t_rready), .rdata(t_rdata), .rresp(t_rresp),
    .core_read_memory(t_rd_mem), .core_write_memory(t_wr_mem),
    .core_address_memory(t_addr), .core_write_data_memory(t_wdat),
    .core_write_strb_memory(t_strb), .core_read_data_memory(32'h0),
    .core_memory_response(1'b0)
  );

  // Memory responder: answers mem_lat cycles after the strobe appears.
  logic        mem_en;
  int          mem_lat;
  logic [31:0] mem [int];
  int          wr_acc = 0, rd_acc = 0, wait_cnt = 0, cur_len = 0, last_len = 0;
  int          stab_bad = 0, resp_cyc = 0;
  int          acc_log[$];
  logic [31:0] last_addr = 0, last_data = 0, mv;
  logic [3:0]  last_strb = 0;

  always @(posedge clk) begin
    #1;
    core_memory_response = 1'b0;
    if (core_write_memory || core_read_memory) begin
      if (cur_len == 0) begin
        last_addr = core_address_memory;
        last_data = core_write_data_memory;
        last_strb = core_write_strb_memory;
      end else if (core_address_memory !== last_addr || core_write_data_memory !== last_data ||
                   core_write_strb_memory !== last_strb) begin
        stab_bad++;
      end
      cur_len++;
      if (mem_en) begin
        if (wait_cnt >= mem_lat) begin
          core_memory_response = 1'b1;
          resp_cyc = cyc;
          wait_cnt = 0;
          mv = mem.exists(int'(core_address_memory)) ? mem[int'(core_address_memory)] : 32'h0;
          if (core_write_memory) begin
            for (int b = 0; b < 4; b++)
              if (core_write_strb_memory[b]) mv[8*b +: 8] = core_write_data_memory[8*b +: 8];
            mem[int'(core_address_memory)] = mv;
            wr_acc++;
            acc_log.push_back(1);
          end else begin
            core_read_data_memory = mv;
            rd_acc++;
            acc_log.push_back(0);
          end
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      if (cur_len != 0) last_len = cur_len;
      cur_len  = 0;
      wait_cnt = 0;
    end
  end

  // Reference memory: what a correct bridge must have stored.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a)] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(input int bdelay, output logic [1:0] resp);
    int n;
    bready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    check("bvalid_seen", 32'(bvalid), 32'h1);
    resp = bresp;
    repeat (bdelay) begin
      @(negedge clk);
      check("bvalid_hold", 32'({bvalid, bresp}), 32'({1'b1, resp}));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input int bdelay,
                          output logic [1:0] resp);
    int n;
    logic ha, hw;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      @(negedge clk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk); #1;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept", 32'({awvalid, wvalid}), 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(bdelay, resp);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay, output logic [31:0] data,
                         output logic [1:0] resp, output int rise_cyc);
    int n;
    logic h;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      @(negedge clk);
      h = arready;
      @(posedge clk); #1;
      if (h) arvalid = 1'b0;
      n++;
    end
    check("ar_accept", 32'(arvalid), 32'h0);
    arvalid = 1'b0;
    rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    check("rvalid_seen", 32'(rvalid), 32'h1);
    data = rdata; resp = rresp; rise_cyc = cyc;
    repeat (rdelay) begin
      @(negedge clk);
      check("rvalid_hold", 32'({rvalid, rresp}), 32'({1'b1, resp}));
      check("rdata_hold", rdata, data);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic arb_round(input logic [31:0] a, d, output logic [31:0] rd,
                           output logic [1:0] br, output logic [1:0] rr);
    int n;
    bit gb, gr;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = 4'hF; araddr = a;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("arb_all_ready", 32'({awready, wready, arready}), 32'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    gb = 0; gr = 0; n = 0; br = 2'b11; rr = 2'b11; rd = 32'h0;
    while (!(gb && gr) && n < 200) begin
      @(negedge clk);
      if (bvalid) begin gb = 1; br = bresp; end
      if (rvalid) begin gr = 1; rr = rresp; rd = rdata; end
      n++;
    end
    check("arb_both_done", 32'({gb, gr}), 32'h3);
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r, r2;
    logic [31:0] rd, a, d, old;
    logic [3:0]  s;
    int          acc0, cy, n, bv, cnt, n0;
    bit          mis;

    reset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    t_awvalid = 0; t_wvalid = 0; t_arvalid = 0; t_bready = 0; t_rready = 0;
    t_awaddr = 0; t_wdata = 0; t_wstrb = 0; t_araddr = 0;
    mem_en = 1'b1; mem_lat = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'({awready, wready, arready}), 32'h7);
    check("reset_valid", 32'({bvalid, rvalid, core_read_memory, core_write_memory}), 32'h0);
    check("reset_resp", 32'({bresp, rresp}), 32'h0);
    check("reset_addr", core_address_memory, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_wdata", core_write_data_memory, 32'h0);
    reset = 1'b0;

    // W three cycles ahead of AW.
    @(posedge clk); #1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("w_ready_empty", 32'(wready), 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("w_ready_full", 32'(wready), 32'h0);
    check("aw_ready_empty", 32'(awready), 32'h1);
    acc0 = wr_acc;
    @(posedge clk); @(posedge clk); #1;
    check("no_strobe_without_aw", 32'(core_write_memory), 32'h0);
    awaddr = 32'h10; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_b(0, r);
    check("s34_bresp", 32'(r), 32'(RESP_OKAY));
    check("s34_one_access", 32'(wr_acc - acc0), 32'h1);
    check("s34_addr", last_addr, 32'h10);
    check("s34_data", last_data, 32'hDEADBEEF);
    check("s34_strb", 32'(last_strb), 32'hF);
    ref_wr(32'h10, 32'hDEADBEEF, 4'hF);

    // Read with slow memory and a stalled rready.
    do_write(32'h20, 32'h12345678, 4'hF, 0, r);
    ref_wr(32'h20, 32'h12345678, 4'hF);
    mem_lat = 5;
    do_read(32'h20, 3, rd, r, cy);
    check("s36_rdata", rd, 32'h12345678);
    check("s36_rresp", 32'(r), 32'(RESP_OKAY));
    check("s36_strobe_len", 32'(last_len), 32'd6);
    check("s36_rvalid_latency", 32'(cy - resp_cyc), 32'h1);
    mem_lat = 0;

    // Misaligned read never reaches memory.
    acc0 = rd_acc;
    do_read(32'h22, 1, rd, r, cy);
    check("s37_rresp", 32'(r), 32'(RESP_SLVERR));
    check("s37_rdata", rd, 32'h0);
    check("s37_no_access", 32'(rd_acc - acc0), 32'h0);

    // Round-robin contest, twice.
    mem_lat = 1;
    n0 = acc_log.size();
    old = ref_rd(32'h40);
    d = $urandom;
    arb_round(32'h40, d, rd, r, r2);
    check("s35a_order_len", 32'(acc_log.size() - n0), 32'h2);
    check("s35a_first_read", 32'(acc_log[n0]), 32'h0);
    check("s35a_second_write", 32'(acc_log[n0 + 1]), 32'h1);
    check("s35a_rdata_old", rd, old);
    check("s35a_resps", 32'({r, r2}), 32'h0);
    ref_wr(32'h40, d, 4'hF);
    d = $urandom;
    arb_round(32'h40, d, rd, r, r2);
    check("s35b_order_len", 32'(acc_log.size() - n0), 32'h4);
    check("s35b_first_write", 32'(acc_log[n0 + 2]), 32'h1);
    check("s35b_second_read", 32'(acc_log[n0 + 3]), 32'h0);
    check("s35b_rdata_new", rd, d);
    ref_wr(32'h40, d, 4'hF);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      mem_lat = int'($urandom_range(0, 3));
      mis = ($urandom_range(0, 5) == 0);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4 + (mis ? 32'($urandom_range(1, 3)) : 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        acc0 = wr_acc;
        do_write(a, d, s, int'($urandom_range(0, 2)), r);
        check("rnd_bresp", 32'(r), mis ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        check("rnd_wr_access", 32'(wr_acc - acc0), mis ? 32'h0 : 32'h1);
        if (!mis) ref_wr(a, d, s);
      end else begin
        acc0 = rd_acc;
        do_read(a, int'($urandom_range(0, 2)), rd, r, cy);
        check("rnd_rresp", 32'(r), mis ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        check("rnd_rdata", rd, mis ? 32'h0 : ref_rd(a));
        check("rnd_rd_access", 32'(rd_acc - acc0), mis ? 32'h0 : 32'h1);
      end
    end
    mem_lat = 0;

    // Reset while a write is waiting on memory.
    mem_en = 1'b0;
    @(posedge clk); #1;
    awaddr = 32'h30; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!core_write_memory && n < 20) begin @(negedge clk); n++; end
    check("s39_in_issue", 32'(core_write_memory), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("s39_async_strobe_drop", 32'({core_write_memory, core_read_memory}), 32'h0);
    check("s39_regs_emptied", 32'({awready, wready}), 32'h3);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    mem_en = 1'b1;
    bv = 0;
    repeat (6) begin @(negedge clk); if (bvalid) bv++; end
    check("s39_no_bvalid", 32'(bv), 32'h0);
    acc0 = wr_acc;
    do_write(32'h30, 32'hA5A55A5A, 4'hF, 1, r);
    check("s39_next_bresp", 32'(r), 32'(RESP_OKAY));
    check("s39_next_access", 32'(wr_acc - acc0), 32'h1);
    ref_wr(32'h30, 32'hA5A55A5A, 4'hF);
    do_read(32'h30, 0, rd, r, cy);
    check("s39_readback", rd, ref_rd(32'h30));

    // Timeout on the short-timeout instance: write then read.
    @(posedge clk); #1;
    t_awaddr = 32'h8; t_wdata = 32'h55AA55AA; t_wstrb = 4'hF; t_awvalid = 1'b1; t_wvalid = 1'b1;
    @(posedge clk); #1;
    t_awvalid = 1'b0; t_wvalid = 1'b0;
    n = 0; cnt = 0;
    while (!t_bvalid && n < 40) begin @(negedge clk); if (t_wr_mem) cnt++; n++; end
    check("s38_wr_strobe_cycles", 32'(cnt), 32'd4);
    check("s38_bvalid", 32'(t_bvalid), 32'h1);
    check("s38_bresp", 32'(t_bresp), 32'(RESP_SLVERR));
    t_bready = 1'b1;
    @(posedge clk); #1;
    t_bready = 1'b0;
    t_araddr = 32'hC; t_arvalid = 1'b1;
    @(posedge clk); #1;
    t_arvalid = 1'b0;
    n = 0; cnt = 0;
    while (!t_rvalid && n < 40) begin @(negedge clk); if (t_rd_mem) cnt++; n++; end
    check("to_rd_strobe_cycles", 32'(cnt), 32'd4);
    check("to_rresp", 32'(t_rresp), 32'(RESP_SLVERR));
    check("to_rdata_zero", t_rdata, 32'h0);
    t_rready = 1'b1;
    @(posedge clk); #1;
    t_rready = 1'b0;

    check("strobe_payload_stable", 32'(stab_bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_mem_bridge.md
AXIL_MEM_BRIDGE -- requirements
Module: axil_mem_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address bus.
REQ-002 Parameter DATA_WIDTH, default 32, data width; legal values 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter ARB_MODE, default 0: 0 = write priority, 1 = read priority, 2 = round-robin.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, maximum wait for a memory response; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 awvalid/awready  in/out  1/1  AXI4-Lite write-address handshake; awaddr  in  ADDR_WIDTH.
REQ-008 wvalid/wready  in/out  1/1  write-data handshake; wdata  in  DATA_WIDTH; wstrb  in  STRB_WIDTH.
REQ-009 bvalid/bready  out/in  1/1  write-response handshake; bresp  out  2.
REQ-010 arvalid/arready  in/out  1/1  read-address handshake; araddr  in  ADDR_WIDTH.
REQ-011 rvalid/rready  out/in  1/1  read-response handshake; rdata  out  DATA_WIDTH; rresp  out  2.
REQ-012 core_read_memory, core_write_memory  out  1  memory request strobes.
REQ-013 core_address_memory  out  ADDR_WIDTH; core_write_data_memory  out  DATA_WIDTH; core_write_strb_memory  out  STRB_WIDTH.
REQ-014 core_read_data_memory  in  DATA_WIDTH; core_memory_response  in  1, one-cycle completion pulse.

Function
REQ-015 AW, W and AR shall each have an independent one-entry holding register; the matching ready signal shall be high only while that register is empty.
REQ-016 AW and W shall be accepted in either order or in the same cycle; a write shall become pending only when both registers are full.
REQ-017 FSM states: IDLE, WR_ISSUE, RD_ISSUE, WR_RESP, RD_RESP.
REQ-018 IDLE: if exactly one request is pending, the FSM shall go to the matching ISSUE state.
REQ-019 IDLE with both requests pending: the winner is chosen by ARB_MODE; in mode 2 the winner is the request type that did not win most recently, and that history resets to "write served last".
REQ-020 The earliest memory strobe assertion shall be the cycle after the completing handshake.
REQ-021 ISSUE: the strobe and address/data/strb outputs shall be held stable until the cycle in which core_memory_response=1, inclusive; the strobe shall be low in the following cycle.
REQ-022 A misaligned address (low log2(STRB_WIDTH) bits nonzero) shall skip the memory access and go directly to RESP with resp=2'b10 (SLVERR).
REQ-023 A timeout counter shall run in ISSUE; if it reaches TIMEOUT_CYCLES without a response, the bridge shall drop the strobe and go to RESP with SLVERR, returning rdata=0 for a read.
REQ-024 For a read, core_read_data_memory shall be captured on the response cycle, and rvalid shall rise in the next cycle with rresp=2'b00.
REQ-025 In RESP, bvalid or rvalid shall be held with stable payload until the corresponding ready is seen; the consumed holding registers shall clear on that handshake, and the FSM shall return to IDLE.
REQ-026 New AW/W/AR requests shall be accepted into empty holding registers in any FSM state.
REQ-027 A core_memory_response outside ISSUE shall be ignored.
REQ-028 At most one memory transaction shall be outstanding at any time.

Reset
REQ-029 On reset, all valid/strobe outputs shall be 0, all ready outputs 1, and data/address/resp outputs 0.
REQ-030 On reset, the FSM shall go to IDLE, holding registers shall be emptied, and the timeout counter and arbitration history shall be cleared.
REQ-031 Reset asserted mid-transaction shall abort that transaction with no response; the first post-reset transaction shall behave as from power-up.

Structure
REQ-032 A shared package bridge_pkg shall hold the FSM state enum, the RESP_OKAY/RESP_SLVERR constants and the ARB_MODE encodings.
REQ-033 One sub-module, axil_skid_reg (one-entry valid/ready holding register, parametrised width), shall be instantiated for each of AW, W and AR.

Verification
REQ-034 Scenario: W before AW by 3 cycles, addr 0x10, data 0xDEADBEEF, strb 0xF -> one core_write_memory assertion with those values; bresp=00.
REQ-035 Scenario: AW, W and AR pending in the same cycle, ARB_MODE=2, last served = write -> read issued first, then write; repeat -> write issued first.
REQ-036 Scenario: read of 0x20, memory returns 0x12345678 with response after 5 cycles -> rdata=0x12345678, rresp=00, rvalid held while rready=0.
REQ-037 Scenario: araddr 0x22 -> no core_read_memory assertion; rresp=10; rdata=0.
REQ-038 Scenario: TIMEOUT_CYCLES=4, no memory response -> strobe high for exactly 4 cycles, then bresp=10.
REQ-039 Scenario: reset pulse while in WR_ISSUE -> strobes drop asynchronously, bvalid never asserts, and the next write completes normally.
